dual_port_ram: RTL and testbench
================================

# dual_port_ram

Parametrised simple dual-port synchronous RAM for the signal-generator datapath (sample buffers, waveform tables, delay lines). Extends the basic one-write/one-read RAM with per-byte write enables, selectable 1- or 2-cycle read latency with a valid flag, defined read-during-write behaviour, and a hardware clear sequencer that zeroes the array after reset or on request.

## Interface
- ADDRESS_WIDTH, 8, address bits; depth = 2**ADDRESS_WIDTH words
- DATA_WIDTH, 8, word width; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, lane width for byte enables; NB = DATA_WIDTH/BYTE_WIDTH
- READ_LATENCY, 1, 1 or 2 clock edges from rd_en to dout
- RDW_MODE, RDW_OLD, same-address read/write collision result (RDW_OLD or RDW_NEW)
- CLEAR_ON_RESET, 1, 1 = run clear sequence automatically on reset release
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  pulse: start clear sequence (accepted only when idle)
- busy  out  1  high while clear sequence runs
- wr_en  in  1  write strobe
- wr_addr  in  ADDRESS_WIDTH  write address
- wr_be  in  NB  byte-lane write enables
- din  in  DATA_WIDTH  write data
- rd_en  in  1  read strobe
- rd_addr  in  ADDRESS_WIDTH  read address
- dout  out  DATA_WIDTH  read data, registered
- dout_valid  out  1  dout carries data from an accepted read

## Operation
- Write: on edge with wr_en=1 and busy=0, lane i (bits [i*BYTE_WIDTH +: BYTE_WIDTH]) of mem[wr_addr] takes din lane i where wr_be[i]=1; other lanes unchanged. wr_be=0 -> no change.
- Read: edge with rd_en=1 and busy=0 accepts a read of rd_addr. rd_en=0 -> dout holds last value, dout_valid=0 for that slot.
- Collision (accepted read and write, rd_addr==wr_addr, same edge): RDW_OLD returns pre-write word; RDW_NEW returns merged word (enabled lanes from din, others old).
- Clear FSM, states S_IDLE, S_CLEAR:
  - S_IDLE -> S_CLEAR on clr=1; counter loaded 0.
  - S_CLEAR: writes zero to mem[counter] each cycle, counter+1; after address 2**ADDRESS_WIDTH-1 written -> S_IDLE. Exactly 2**ADDRESS_WIDTH cycles.
  - clr in S_CLEAR ignored (no restart).
  - busy = (state==S_CLEAR).
- While busy: wr_en, rd_en ignored; no new dout_valid generated.
- Reset (async assert, any time incl. mid-clear): state -> S_CLEAR if CLEAR_ON_RESET else S_IDLE; counter=0; dout=0; dout_valid=0; busy=CLEAR_ON_RESET; pipeline stage regs=0. Array contents not reset by rst_n itself.

## Timing
- READ_LATENCY=1: read accepted at edge N -> dout/dout_valid updated at edge N; visible cycle N..N+1.
- READ_LATENCY=2: extra register stage; data and valid appear one edge later (edge N+1). Back-to-back reads stream one word per cycle at both latencies.
- Write at edge N visible to a non-colliding read accepted at edge N+1.
- Clear completes on edge 2**ADDRESS_WIDTH after entry; busy falls that edge; first accepted access next edge.
- Reset release: with CLEAR_ON_RESET=1, busy already high; first clear write on first clock edge after rst_n rises.

## Structure
- Package ram_pkg: rdw_mode_e {RDW_OLD, RDW_NEW}; clr_state_e {S_IDLE, S_CLEAR}; function num_lanes(data_w, byte_w).
- Elaboration checks: DATA_WIDTH % BYTE_WIDTH == 0, READ_LATENCY in {1,2}; fatal otherwise.
- Sub-module ram_out_stage: optional second output register (data + valid, async reset), instantiated when READ_LATENCY==2.

## Test plan
- Reset release, CLEAR_ON_RESET=1, AW=4 -> busy high 16 cycles; then reads of 0..15 return 0x00, dout_valid high per read.
- DATA_WIDTH=16, write 0xABCD be=2'b11 addr 3, then 0x1234 be=2'b01 -> read addr 3 returns 0xAB34.
- Same-edge write 0x55 / read addr 7 (old 0x11): RDW_OLD -> 0x11; RDW_NEW -> 0x55; next read -> 0x55.
- READ_LATENCY=2, reads addr 1,2,3 back-to-back -> dout/valid one edge later than latency-1 build, three consecutive valid words.
- clr pulse mid-operation, wr_en/rd_en held high during busy -> no writes land, dout_valid stays 0, all words 0 after; second clr during busy does not extend busy.
- rst_n asserted mid-clear -> outputs zero immediately; after release clear restarts from address 0, full 2**ADDRESS_WIDTH cycles.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and helpers for the signal-generator dual-port RAM.
package ram_pkg;

  typedef enum logic {
    RDW_OLD,
    RDW_NEW
  } rdw_mode_e;

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } clr_state_e;

  function automatic int num_lanes(int data_w, int byte_w);
    return data_w / byte_w;
  endfunction

endpackage

// File: rtl/ram_out_stage.sv
// Optional second read register: data and valid delayed one edge.
// Data holds its last value when no valid word passes through.
module ram_out_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] d,
  input  logic          vld,
  output logic [DW-1:0] q,
  output logic          q_vld
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= '0;
      q_vld <= 1'b0;
    end else begin
      q_vld <= vld;
      if (vld) q <= d;
    end
  end

endmodule

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM with byte enables, 1/2-cycle reads,
// defined read-during-write and a hardware clear sequencer.
module dual_port_ram
  import ram_pkg::*;
#(
  parameter int        ADDRESS_WIDTH  = 8,
  parameter int        DATA_WIDTH     = 8,
  parameter int        BYTE_WIDTH     = 8,
  parameter int        READ_LATENCY   = 1,
  parameter rdw_mode_e RDW_MODE       = RDW_OLD,
  parameter bit        CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  output logic                     busy,
  input  logic                     wr_en,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [num_lanes(DATA_WIDTH, BYTE_WIDTH)-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     rd_en,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     dout_valid
);

  localparam int NB    = num_lanes(DATA_WIDTH, BYTE_WIDTH);
  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam clr_state_e RST_STATE =
    CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_bw
    $fatal(1, "DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $fatal(1, "READ_LATENCY must be 1 or 2");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  clr_state_e               state, state_d;
  logic [ADDRESS_WIDTH-1:0] cnt, cnt_d;

  logic wr_acc;
  logic rd_acc;

  assign busy   = (state == S_CLEAR);
  assign wr_acc = wr_en & ~busy;
  assign rd_acc = rd_en & ~busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      S_IDLE: begin
        if (clr) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        cnt_d = cnt + 1'b1;
        if (cnt == ADDRESS_WIDTH'(DEPTH - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Array has no reset; the clear sequencer owns it while busy.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i])
          mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
            din[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  logic [DATA_WIDTH-1:0] rd_old;
  logic [DATA_WIDTH-1:0] rd_new;
  logic [DATA_WIDTH-1:0] rd_word;

  always_comb begin
    rd_old = mem[rd_addr];
    rd_new = rd_old;
    if (wr_acc && wr_addr == rd_addr) begin
      for (int i = 0; i < NB; i++) begin
        if (wr_be[i])
          rd_new[i*BYTE_WIDTH +: BYTE_WIDTH] =
            din[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign rd_word = (RDW_MODE == RDW_NEW) ? rd_new : rd_old;

  logic [DATA_WIDTH-1:0] d1;
  logic                  v1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= rd_acc;
      if (rd_acc) d1 <= rd_word;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    ram_out_stage #(
      .DW (DATA_WIDTH)
    ) u_out_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d1),
      .vld   (v1),
      .q     (dout),
      .q_vld (dout_valid)
    );
  end else begin : g_lat1
    assign dout       = d1;
    assign dout_valid = v1;
  end

endmodule

// File: tb/tb_dual_port_ram.sv
// Scoreboard bench: RDW_OLD/latency-1 and RDW_NEW/latency-2
// instances share stimulus and are checked against one model.
module tb_dual_port_ram;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [1:0]  wr_be;
  logic [15:0] din;
  logic        rd_en;
  logic [3:0]  rd_addr;

  logic        busy_a, busy_b;
  logic [15:0] dout_a, dout_b;
  logic        dv_a, dv_b;

  dual_port_ram #(
    .ADDRESS_WIDTH  (4),
    .DATA_WIDTH     (16),
    .BYTE_WIDTH     (8),
    .READ_LATENCY   (1),
    .RDW_MODE       (ram_pkg::RDW_OLD),
    .CLEAR_ON_RESET (1'b1)
  ) u_old (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .busy       (busy_a),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_be      (wr_be),
    .din        (din),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .dout       (dout_a),
    .dout_valid (dv_a)
  );

  dual_port_ram #(
    .ADDRESS_WIDTH  (4),
    .DATA_WIDTH     (16),
    .BYTE_WIDTH     (8),
    .READ_LATENCY   (2),
    .RDW_MODE       (ram_pkg::RDW_NEW),
    .CLEAR_ON_RESET (1'b1)
  ) u_new (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .busy       (busy_b),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_be      (wr_be),
    .din        (din),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .dout       (dout_b),
    .dout_valid (dv_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [15:0] mem_m [16];
  logic        busy_m;
  logic [3:0]  cnt_m;
  logic [15:0] last_a, last_b;
  int          cyc;
  int          n_chk;
  int          n_err;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic we, input logic [3:0] wa,
                      input logic [1:0] be, input logic [15:0] d,
                      input logic re, input logic [3:0] ra,
                      input logic c);
    logic [15:0] old_w, new_w;
    wr_en   = we;
    wr_addr = wa;
    wr_be   = be;
    din     = d;
    rd_en   = re;
    rd_addr = ra;
    clr     = c;
    if (!busy_m && re) begin
      old_w = mem_m[ra];
      new_w = old_w;
      if (we && wa == ra) begin
        if (be[0]) new_w[7:0]  = d[7:0];
        if (be[1]) new_w[15:8] = d[15:8];
      end
      qa.push_back('{cyc + 1, old_w});
      qb.push_back('{cyc + 2, new_w});
    end
    if (busy_m) begin
      mem_m[cnt_m] = 16'h0;
      if (cnt_m == 4'hF) busy_m = 1'b0;
      cnt_m = cnt_m + 4'd1;
    end else begin
      if (we) begin
        if (be[0]) mem_m[wa][7:0]  = d[7:0];
        if (be[1]) mem_m[wa][15:8] = d[15:8];
      end
      if (c) begin
        busy_m = 1'b1;
        cnt_m  = 4'd0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check("busy_a", 32'(busy_a), 32'(busy_m));
    check("busy_b", 32'(busy_b), 32'(busy_m));
    if (qa.size() > 0 && qa[0].due == cyc) begin
      check("vld_a", 32'(dv_a), 32'd1);
      check("dout_a", 32'(dout_a), 32'(qa[0].data));
      last_a = qa[0].data;
      qa.delete(0);
    end else begin
      check("idle_vld_a", 32'(dv_a), 32'd0);
      check("hold_a", 32'(dout_a), 32'(last_a));
    end
    if (qb.size() > 0 && qb[0].due == cyc) begin
      check("vld_b", 32'(dv_b), 32'd1);
      check("dout_b", 32'(dout_b), 32'(qb[0].data));
      last_b = qb[0].data;
      qb.delete(0);
    end else begin
      check("idle_vld_b", 32'(dv_b), 32'd0);
      check("hold_b", 32'(dout_b), 32'(last_b));
    end
  endtask

  task automatic idle();
    step(1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [1:0] be,
                    input logic [15:0] d);
    step(1'b1, a, be, d, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a);
    step(1'b0, 4'd0, 2'b00, 16'h0, 1'b1, a, 1'b0);
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < 16; i++) rd(4'(i));
    idle();
    idle();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy_a", 32'(busy_a), 32'd1);
    check("rst_busy_b", 32'(busy_b), 32'd1);
    check("rst_dout_a", 32'(dout_a), 32'd0);
    check("rst_dout_b", 32'(dout_b), 32'd0);
    check("rst_vld_a", 32'(dv_a), 32'd0);
    check("rst_vld_b", 32'(dv_b), 32'd0);
    qa.delete();
    qb.delete();
    last_a = 16'h0;
    last_b = 16'h0;
    busy_m = 1'b1;
    cnt_m  = 4'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    cyc     = 0;
    rst_n   = 1'b1;
    clr     = 1'b0;
    wr_en   = 1'b0;
    wr_addr = 4'd0;
    wr_be   = 2'b00;
    din     = 16'h0;
    rd_en   = 1'b0;
    rd_addr = 4'd0;
    for (int i = 0; i < 16; i++) mem_m[i] = 16'hDEAD;

    do_reset();
    for (int i = 0; i < 16; i++) idle();
    read_all_zero();

    wr(4'd3, 2'b11, 16'hABCD);
    wr(4'd3, 2'b01, 16'h1234);
    rd(4'd3);
    idle();
    idle();

    wr(4'd7, 2'b11, 16'h0011);
    step(1'b1, 4'd7, 2'b11, 16'h0055, 1'b1, 4'd7, 1'b0);
    rd(4'd7);
    step(1'b1, 4'd7, 2'b10, 16'hEE99, 1'b1, 4'd7, 1'b0);
    rd(4'd7);
    idle();
    idle();

    wr(4'd1, 2'b11, 16'h1111);
    wr(4'd2, 2'b11, 16'h2222);
    wr(4'd3, 2'b11, 16'h3333);
    rd(4'd1);
    rd(4'd2);
    rd(4'd3);
    idle();
    idle();
    idle();

    for (int i = 0; i < 200; i++) begin
      logic [3:0] wa;
      wa = 4'($urandom);
      step(1'($urandom), wa, 2'($urandom), 16'($urandom),
           1'($urandom), ($urandom_range(3) == 0) ? wa : 4'($urandom),
           1'b0);
    end
    idle();
    idle();

    step(1'b1, 4'd5, 2'b11, 16'hC0DE, 1'b1, 4'd5, 1'b1);
    for (int k = 0; k < 16; k++)
      step(1'b1, 4'(k), 2'b11, 16'hFFFF, 1'b1, 4'(k), k == 5);
    read_all_zero();

    wr(4'd9, 2'b11, 16'h9999);
    step(1'b0, 4'd0, 2'b00, 16'h0, 1'b0, 4'd0, 1'b1);
    for (int k = 0; k < 5; k++) idle();
    do_reset();
    for (int k = 0; k < 16; k++)
      step(1'b1, 4'(k), 2'b11, 16'hFFFF, 1'b1, 4'(k), 1'b0);
    read_all_zero();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
